// File: rtl/tarhi_pkg.sv
// rtl/tarhi_pkg.sv - shared bus widths, MMIO offsets and FSM encoding for the tarhi core
package tarhi_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    localparam logic [1:0] MMIO_GPO  = 2'd0;
    localparam logic [1:0] MMIO_GPI  = 2'd1;
    localparam logic [1:0] MMIO_CNT  = 2'd2;
    localparam logic [1:0] MMIO_STAT = 2'd3;

    localparam logic [DATA_W-1:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/tarhi_ram.sv
// rtl/tarhi_ram.sv - single-port word RAM, asynchronous read, synchronous write
module tarhi_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/tarhi_mem_responder.sv
// rtl/tarhi_mem_responder.sv - RAM + MMIO responder on the tarhi core word bus, clears RAM after reset
module tarhi_mem_responder
    import tarhi_pkg::*;
#(
    parameter int         AW   = 10,
    parameter logic [3:0] MMIO = 4'hF,
    parameter int         GPW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_reset,
    input  logic [GPW-1:0]    gpio_in,
    output logic [GPW-1:0]    gpio_out
);

    state_t              state;
    logic [AW-1:0]       clr_ptr;
    logic [GPW-1:0]      gpi_meta;
    logic [GPW-1:0]      gpi_sync;
    logic [DATA_W-1:0]   counter;
    logic                err;

    logic                sel_ram;
    logic                sel_mmio;
    logic [1:0]          reg_sel;
    logic                ram_we;
    logic [AW-1:0]       ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    // Full-width compare so addresses above the RAM never alias back into it.
    assign sel_ram  = (cpu_addr[ADDR_W-1:AW] == '0);
    assign sel_mmio = (cpu_addr[ADDR_W-1:ADDR_W-4] == MMIO);
    assign reg_sel  = cpu_addr[1:0];

    // While clearing, the sweep owns the RAM port and the core is locked out.
    assign ram_we    = (state == CLEAR) || (cpu_we && sel_ram);
    assign ram_addr  = (state == CLEAR) ? clr_ptr : cpu_addr[AW-1:0];
    assign ram_wdata = (state == CLEAR) ? '0 : cpu_wdata;

    tarhi_ram #(
        .AW (AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        cpu_rdata = UNMAPPED_DATA;
        if (state == CLEAR) begin
            cpu_rdata = '0;
        end else if (sel_ram) begin
            cpu_rdata = ram_rdata;
        end else if (sel_mmio) begin
            case (reg_sel)
                MMIO_GPO:  cpu_rdata = DATA_W'(gpio_out);
                MMIO_GPI:  cpu_rdata = DATA_W'(gpi_sync);
                MMIO_CNT:  cpu_rdata = counter;
                default:   cpu_rdata = {30'b0, err, 1'b1};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            cpu_reset <= 1'b1;
            gpio_out  <= '0;
            gpi_meta  <= '0;
            gpi_sync  <= '0;
            counter   <= '0;
            err       <= 1'b0;
        end else begin
            gpi_meta <= gpio_in;
            gpi_sync <= gpi_meta;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    counter <= '0;
                    if (clr_ptr == '1) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                    end
                end
                RUN: begin
                    counter <= counter + DATA_W'(1);
                    if (cpu_we && !sel_ram) begin
                        if (sel_mmio) begin
                            if (reg_sel == MMIO_GPO) begin
                                gpio_out <= cpu_wdata[GPW-1:0];
                            end
                            // A clearing write wins over the increment above.
                            if (reg_sel == MMIO_CNT) begin
                                counter <= '0;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_tarhi_mem_responder.sv
// tb/tb_tarhi_mem_responder.sv - scoreboard bench for tarhi_mem_responder with AW=4, GPW=8
module tb_tarhi_mem_responder;

    localparam int K_RDATA = 0;
    localparam int K_RST   = 1;
    localparam int K_GPO   = 2;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_reset;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        rd_req = 1'b0;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    tarhi_mem_responder #(
        .AW   (4),
        .MMIO (4'hF),
        .GPW  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_reset (cpu_reset),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_req) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL no_expectation: sample strobe with empty scoreboard");
            end
            while (q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = q.pop_front();
                case (e.kind)
                    K_RDATA: act = cpu_rdata;
                    K_RST:   act = {31'b0, cpu_reset};
                    default: act = {24'b0, gpio_out};
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic sample();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic rd(input logic [23:0] a, input logic [31:0] v, input string nm);
        cpu_we   = 1'b0;
        cpu_addr = a;
        push_exp(K_RDATA, v, nm);
        sample();
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        step();
        cpu_we    = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        push_exp(K_RST, 1, "rst_in_reset");
        push_exp(K_GPO, 0, "gpo_reset");
        sample();
        reset = 1'b0;

        // Clear sweep: core writes must be ignored and reads must return 0.
        for (int i = 0; i < 16; i++) begin
            cpu_we    = 1'b1;
            cpu_wdata = 32'hAAAA_5555;
            if (i == 0)      cpu_addr = 24'hF00000;
            else if (i == 1) cpu_addr = 24'h800000;
            else             cpu_addr = 24'(i - 1);
            push_exp(K_RST, 1, $sformatf("clear_rst_%0d", i));
            push_exp(K_RDATA, 0, $sformatf("clear_rdata_%0d", i));
            sample();
        end
        cpu_we = 1'b0;
        push_exp(K_RST, 0, "run_rst_low");
        push_exp(K_GPO, 0, "gpo_after_clear");
        sample();

        for (int i = 0; i < 16; i++) begin
            rd(24'(i), 32'h0, $sformatf("ram_zero_%0d", i));
        end
        rd(24'hF00003, 32'h1, "status_clean");

        cpu_addr  = 24'd5;
        cpu_wdata = 32'h1234_5678;
        cpu_we    = 1'b1;
        push_exp(K_RDATA, 0, "raw_old_data");
        sample();
        cpu_we = 1'b0;
        rd(24'd5, 32'h1234_5678, "raw_new_data");
        rd(24'd6, 32'h0, "ram_neighbour");
        rd(24'd16, 32'hDEAD_BEEF, "above_ram");
        rd(24'h000100, 32'hDEAD_BEEF, "far_above_ram");

        wr(24'hF00000, 32'hFFFF_FFA5);
        push_exp(K_GPO, 32'hA5, "gpo_pin");
        rd(24'hF00000, 32'h0000_00A5, "gpo_read");
        rd(24'hF3FFF0, 32'h0000_00A5, "gpo_alias");

        gpio_in = 8'h3C;
        rd(24'hF00001, 32'h0, "gpi_edge0");
        rd(24'hF00001, 32'h0, "gpi_edge1");
        rd(24'hF00001, 32'h0000_003C, "gpi_edge2");

        wr(24'hF00002, 32'h1234);
        rd(24'hF00002, 32'h0, "cnt_cleared");
        repeat (99) step();
        rd(24'hF00002, 32'd100, "cnt_100");

        force dut.counter = 32'hFFFF_FFFF;
        #1;
        release dut.counter;
        rd(24'hF00002, 32'hFFFF_FFFF, "cnt_forced");
        rd(24'hF00002, 32'h0, "cnt_wrap");

        wr(24'h800000, 32'hDEAD_0001);
        rd(24'hF00003, 32'h3, "status_err");
        rd(24'd0, 32'h0, "ram0_untouched");
        rd(24'd5, 32'h1234_5678, "ram5_untouched");
        wr(24'hF00003, 32'h0);
        wr(24'hF00001, 32'hFFFF_FFFF);
        rd(24'hF00003, 32'h3, "status_sticky");
        rd(24'hF00001, 32'h0000_003C, "gpi_ro");

        // Reset in the middle of a clear must restart the sweep from 0.
        wr(24'd12, 32'hCAFE_F00D);
        rd(24'd12, 32'hCAFE_F00D, "ram12_written");
        reset = 1'b1;
        step();
        push_exp(K_RST, 1, "rst2_in_reset");
        sample();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_exp(K_RST, 1, $sformatf("clear1_rst_%0d", i));
            sample();
        end
        reset = 1'b1;
        push_exp(K_RST, 1, "midclear_reset");
        sample();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_exp(K_RST, 1, $sformatf("clear2_rst_%0d", i));
            sample();
        end
        cpu_addr = 24'd12;
        push_exp(K_RST, 0, "run2_rst_low");
        push_exp(K_RDATA, 0, "ram12_cleared");
        sample();
        rd(24'd5, 32'h0, "ram5_cleared");
        rd(24'hF00003, 32'h1, "err_cleared");
        push_exp(K_GPO, 0, "gpo_after_reset");
        sample();

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
